// File: rtl/lead_1_pkg.sv
// lead_1_pkg: shared types for the iterative set-bit scanner.
//   scan_dir_t   - scan order of a word (MSB-first or LSB-first)
//   scan_state_t - scanner control state
package lead_1_pkg;

  typedef enum logic {DIR_MSB, DIR_LSB} scan_dir_t;

  typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

endpackage : lead_1_pkg

// File: rtl/lead_1_pe.sv
// lead_1_pe: combinational, parametrised priority encoder.
//   data   [N-1:0] word to encode
//   dir            DIR_MSB selects the highest set bit, DIR_LSB the lowest
//   index  [W-1:0] position of the selected bit (0 when data is all-zero)
//   valid          at least one bit of data is set
//   onehot [N-1:0] the selected bit alone (all-zero when !valid)
//   multi          more than one bit of data is set
module lead_1_pe
  import lead_1_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] data,
  input  scan_dir_t    dir,
  output logic [W-1:0] index,
  output logic         valid,
  output logic [N-1:0] onehot,
  output logic         multi
);

  // The loop runs towards the winning end, so the last hit seen is the
  // one selected.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    index = '0;
    valid = 1'b0;
    if (dir == DIR_MSB) begin
      for (int i = 0; i < N; i++) begin
        if (data[i]) begin
          index = W'(i);
          valid = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (data[i]) begin
          index = W'(i);
          valid = 1'b1;
        end
      end
    end
  end

  assign onehot = valid ? (N'(1) << index) : '0;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(data & (data - N'(1)));

endmodule : lead_1_pe

// File: rtl/lead_1_scan.sv
// lead_1_scan: accepts an N-bit word and streams the index of every set bit,
// one per beat, MSB-first or LSB-first as chosen with the word.
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready             input word handshake
//   in_data [N-1:0], in_lsb_first word and its scan order
//   out_valid/out_ready           beat handshake
//   out_index [W-1:0]             bit position of the current set bit
//   out_seq   [W-1:0]             beat number within the word
//   out_last                      final beat of the word
//   out_empty                     the word was all-zero (single beat)
module lead_1_scan
  import lead_1_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_lsb_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_index,
  output logic [W-1:0] out_seq,
  output logic         out_last,
  output logic         out_empty
);

  scan_state_t  state, state_n;
  logic [N-1:0] resid, resid_n;
  scan_dir_t    dir, dir_n;
  logic [W-1:0] seq, seq_n;
  logic         empty, empty_n;

  logic [W-1:0] pe_index;
  logic         pe_valid;
  logic [N-1:0] pe_onehot;
  logic         pe_multi;
  logic         in_fire, out_fire;

  lead_1_pe #(.N(N)) u_pe (
    .data   (resid),
    .dir    (dir),
    .index  (pe_index),
    .valid  (pe_valid),
    .onehot (pe_onehot),
    .multi  (pe_multi)
  );

  assign out_index = pe_valid ? pe_index : '0;
  assign out_seq   = seq;
  assign out_last  = !pe_multi;
  assign out_empty = empty;

  // Both handshake outputs are held low while reset is asserted.
  assign out_valid = rst_n && (state == S_SCAN);
  // Accepting during the final beat lets the next word follow without a bubble.
  assign in_ready  = rst_n && ((state == S_IDLE) ||
                               ((state == S_SCAN) && out_last && out_ready));

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_n = state;
    resid_n = resid;
    dir_n   = dir;
    seq_n   = seq;
    empty_n = empty;
    if (in_fire) begin
      state_n = S_SCAN;
      resid_n = in_data;
      dir_n   = scan_dir_t'(in_lsb_first);
      seq_n   = '0;
      empty_n = (in_data == '0);
    end else if (out_fire) begin
      if (out_last) begin
        state_n = S_IDLE;
      end else begin
        resid_n = resid & ~pe_onehot;
        seq_n   = seq + W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      resid <= '0;
      dir   <= DIR_MSB;
      seq   <= '0;
      empty <= 1'b0;
    end else begin
      state <= state_n;
      resid <= resid_n;
      dir   <= dir_n;
      seq   <= seq_n;
      empty <= empty_n;
    end
  end

endmodule : lead_1_scan

// File: tb/tb_lead_1_scan.sv
// tb_lead_1_scan: scoreboard bench for lead_1_scan (N=8 and N=16 instances).
// Expected beats are pushed when a word is accepted; monitors collect the
// beats each instance emits, and each test pops and compares them.
module tb_lead_1_scan;

  typedef struct packed {
    logic [3:0] index;
    logic [3:0] seq;
    logic       last;
    logic       empty;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;

  logic       in_valid, in_ready, in_lsb_first, out_valid, out_ready;
  logic [7:0] in_data;
  logic [2:0] out_index, out_seq;
  logic       out_last, out_empty;

  logic        in_valid16, in_ready16, in_lsb_first16, out_valid16, out_ready16;
  logic [15:0] in_data16;
  logic [3:0]  out_index16, out_seq16;
  logic        out_last16, out_empty16;

  int    cyc = 0;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  beat_t exp_q[$];
  obs_t  obs8_q[$];
  obs_t  obs16_q[$];

  lead_1_scan #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_lsb_first(in_lsb_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_seq(out_seq), .out_last(out_last), .out_empty(out_empty)
  );

  lead_1_scan #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .in_lsb_first(in_lsb_first16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_index(out_index16),
    .out_seq(out_seq16), .out_last(out_last16), .out_empty(out_empty16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t make_obs(input logic [3:0] idx, input logic [3:0] sq,
                                    input logic lst, input logic emp, input int c);
    obs_t o;
    o.b.index = idx;
    o.b.seq   = sq;
    o.b.last  = lst;
    o.b.empty = emp;
    o.cyc     = c;
    return o;
  endfunction

  // Beats are collected on the falling edge, where a handshake seen here
  // completes at the following rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready)
      obs8_q.push_back(make_obs(4'(out_index), 4'(out_seq), out_last, out_empty, cyc));
    if (out_valid16 && out_ready16)
      obs16_q.push_back(make_obs(out_index16, out_seq16, out_last16, out_empty16, cyc));
  end

  // Reference model: list the set bits of d in scan order.
  function automatic void push_exp(input logic [15:0] d, input bit lsb, input int n);
    int    idx[$];
    beat_t b;
    for (int i = 0; i < n; i++) begin
      int p;
      p = lsb ? i : n - 1 - i;
      if (d[p]) idx.push_back(p);
    end
    if (idx.size() == 0) begin
      b.index = 4'd0; b.seq = 4'd0; b.last = 1'b1; b.empty = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < idx.size(); k++) begin
        b.index = 4'(idx[k]);
        b.seq   = 4'(k);
        b.last  = (k == idx.size() - 1);
        b.empty = 1'b0;
        exp_q.push_back(b);
      end
    end
  endfunction

  // Offer a word to the N=8 instance; called just after a rising edge.
  task automatic send8(input logic [7:0] d, input bit lsb, output int acc, output bit ok);
    bit rdy;
    ok = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_data = d;
    in_lsb_first = lsb;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        acc = cyc;
        push_exp({8'h00, d}, lsb, 8);
      end
    end
    in_valid = 1'b0;
    in_data = 8'h5A;
  endtask

  task automatic wait_beats8(input int n, output bit ok);
    for (int t = 0; t < 100 && obs8_q.size() < n; t++) begin
      @(posedge clk);
      #1;
    end
    ok = (obs8_q.size() >= n);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b00)
        $display("FAIL reset_hs: got valid/ready=%b%b, want 00", out_valid, in_ready);
      else pass_cnt++;
      total_cnt++;
      if ({out_valid16, in_ready16} !== 2'b00)
        $display("FAIL reset_hs16: got valid/ready=%b%b, want 00", out_valid16, in_ready16);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL release_hs: got valid/ready=%b%b, want 01", out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({out_seq, out_empty} !== 4'b0000)
      $display("FAIL reset_regs: got seq=%0d empty=%b, want seq=0 empty=0", out_seq, out_empty);
    else pass_cnt++;
    total_cnt++;
    if ({out_valid16, in_ready16} !== 2'b01)
      $display("FAIL release_hs16: got valid/ready=%b%b, want 01", out_valid16, in_ready16);
    else pass_cnt++;
  endtask

  // Send one word with out_ready high, compare every beat and its cycle,
  // then confirm the scanner is idle again.
  task automatic test_stream(input logic [7:0] d, input bit lsb, input string name);
    int acc, n;
    bit ok;
    beat_t e;
    obs_t  o;
    out_ready = 1'b1;
    send8(d, lsb, acc, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL %s accept: got in_ready=0 for 50 cycles, want accept", name);
      return;
    end
    pass_cnt++;
    n = exp_q.size();
    wait_beats8(n, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL %s beats: got %0d beats, want %0d", name, obs8_q.size(), n);
      exp_q.delete(); obs8_q.delete();
      return;
    end
    pass_cnt++;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = obs8_q.pop_front();
      total_cnt++;
      if (o.b !== e)
        $display("FAIL %s beat%0d: got idx=%0d seq=%0d last=%b empty=%b, want idx=%0d seq=%0d last=%b empty=%b",
                 name, i, o.b.index, o.b.seq, o.b.last, o.b.empty, e.index, e.seq, e.last, e.empty);
      else pass_cnt++;
      total_cnt++;
      if (o.cyc !== acc + i)
        $display("FAIL %s cycle%0d: got cycle %0d, want %0d", name, i, o.cyc, acc + i);
      else pass_cnt++;
    end
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL %s idle: got valid/ready=%b%b, want 01", name, out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int acc, c;
    bit ok;
    beat_t e;
    obs_t  o;
    out_ready = 1'b1;
    send8(8'hFF, 1'b0, acc, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL stall accept: got in_ready=0 for 50 cycles, want accept");
      return;
    end
    pass_cnt++;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({out_valid, out_index, out_seq, out_last} !== {1'b1, 3'd6, 3'd1, 1'b0})
        $display("FAIL stall_hold%0d: got valid=%b idx=%0d seq=%0d last=%b, want valid=1 idx=6 seq=1 last=0",
                 i, out_valid, out_index, out_seq, out_last);
      else pass_cnt++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_beats8(8, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL stall beats: got %0d beats, want 8", obs8_q.size());
      exp_q.delete(); obs8_q.delete();
      return;
    end
    pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      o = obs8_q.pop_front();
      c = (i == 0) ? acc : acc + 3 + i;
      total_cnt++;
      if (o.b !== e)
        $display("FAIL stall beat%0d: got idx=%0d seq=%0d last=%b, want idx=%0d seq=%0d last=%b",
                 i, o.b.index, o.b.seq, o.b.last, e.index, e.seq, e.last);
      else pass_cnt++;
      total_cnt++;
      if (o.cyc !== c)
        $display("FAIL stall cycle%0d: got cycle %0d, want %0d", i, o.cyc, c);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int a, a2;
    bit ok;
    beat_t e;
    obs_t  o;
    out_ready = 1'b1;
    send8(8'h81, 1'b0, a, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL b2b accept1: got in_ready=0 for 50 cycles, want accept");
      return;
    end
    pass_cnt++;
    @(posedge clk);
    #1;
    send8(8'h10, 1'b0, a2, ok);
    total_cnt++;
    if (!ok || a2 !== a + 2)
      $display("FAIL b2b accept2: got accepted=%b at cycle %0d, want accepted at %0d", ok, a2, a + 2);
    else pass_cnt++;
    wait_beats8(3, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL b2b beats: got %0d beats, want 3", obs8_q.size());
      exp_q.delete(); obs8_q.delete();
      return;
    end
    pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = obs8_q.pop_front();
      total_cnt++;
      if (o.b !== e || o.cyc !== a + i)
        $display("FAIL b2b beat%0d: got idx=%0d seq=%0d last=%b cycle=%0d, want idx=%0d seq=%0d last=%b cycle=%0d",
                 i, o.b.index, o.b.seq, o.b.last, o.cyc, e.index, e.seq, e.last, a + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    beat_t e;
    obs_t  o;
    out_ready = 1'b1;
    send8(8'hFF, 1'b0, acc, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL rstmid accept: got in_ready=0 for 50 cycles, want accept");
      return;
    end
    pass_cnt++;
    wait_beats8(3, ok);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b00)
      $display("FAIL rstmid_hs: got valid/ready=%b%b, want 00", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    total_cnt++;
    if (obs8_q.size() !== 3) begin
      $display("FAIL rstmid beats: got %0d beats before reset, want 3", obs8_q.size());
      obs8_q.delete();
    end else begin
      pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        o = obs8_q.pop_front();
        total_cnt++;
        if (o.b !== e)
          $display("FAIL rstmid beat%0d: got idx=%0d seq=%0d, want idx=%0d seq=%0d",
                   i, o.b.index, o.b.seq, e.index, e.seq);
        else pass_cnt++;
      end
    end
    // The rest of the word is abandoned by the reset.
    exp_q.delete();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (obs8_q.size() !== 0 || {out_valid, in_ready} !== 2'b01)
      $display("FAIL rstmid_after: got %0d extra beats valid/ready=%b%b, want 0 beats and 01",
               obs8_q.size(), out_valid, in_ready);
    else pass_cnt++;
    obs8_q.delete();
    test_stream(8'h80, 1'b0, "after_reset");
  endtask

  task automatic test_n16();
    bit    rdy, ok;
    beat_t e;
    obs_t  o;
    ok = 1'b0;
    out_ready16 = 1'b1;
    in_valid16 = 1'b1;
    in_data16 = 16'h8001;
    in_lsb_first16 = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      rdy = in_ready16;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        push_exp(16'h8001, 1'b0, 16);
      end
    end
    in_valid16 = 1'b0;
    for (int t = 0; t < 100 && obs16_q.size() < 2; t++) begin
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (!ok || obs16_q.size() !== 2) begin
      $display("FAIL n16 beats: got accepted=%b beats=%0d, want accepted with 2 beats", ok, obs16_q.size());
      exp_q.delete(); obs16_q.delete();
      return;
    end
    pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      o = obs16_q.pop_front();
      total_cnt++;
      if (o.b !== e)
        $display("FAIL n16 beat%0d: got idx=%0d seq=%0d last=%b, want idx=%0d seq=%0d last=%b",
                 i, o.b.index, o.b.seq, o.b.last, e.index, e.seq, e.last);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_lsb_first = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_data16 = 16'h0000; in_lsb_first16 = 1'b0; out_ready16 = 1'b1;
    test_reset();
    test_stream(8'b1010_0100, 1'b0, "msb_a4");
    test_stream(8'b1010_0100, 1'b1, "lsb_a4");
    test_stream(8'h00, 1'b0, "zero");
    test_stream(8'hFF, 1'b1, "lsb_ff");
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_n16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_lead_1_scan
